// File: rtl/spi_frame_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_frame_master: mode-0 SPI master exchanging ID+payload frames; optional
// reply checking when SPI_FRAME_EXPECT_EN is defined.    Revision: 1.0
// ----------------------------------------------------------------------------
module spi_frame_master #(
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 4,
   parameter int FRAME_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [3:0]            tx_id,
   input  logic [FRAME_BITS-5:0] tx_data,
   output logic                  rx_valid,
   output logic [3:0]            rx_id,
   output logic [FRAME_BITS-5:0] rx_data,
   output logic                  busy,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_cs
`ifdef SPI_FRAME_EXPECT_EN
   ,
   input  logic                  exp_valid,
   input  logic [3:0]            exp_id,
   input  logic [FRAME_BITS-5:0] exp_data,
   output logic                  exp_err,
   output logic [15:0]           err_count
`endif
);

   localparam int              EW        = $clog2(2 * FRAME_BITS);
   localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0]      GAP_LAST  = 8'(CS_GAP - 1);
   localparam logic [EW-1:0]   EDGE_LAST = EW'(2 * FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t                  state, state_nx;
   logic [7:0]              cnt;
   logic [EW-1:0]           edge_cnt;
   logic [FRAME_BITS-1:0]   tx_sh;
   logic [FRAME_BITS-1:0]   rx_sh;
   logic                    miso_m, miso_s;
   logic                    div_done, accept, sample, active_nx, frame_done;

   assign div_done   = (cnt == DIV_LAST);
   assign accept     = tx_valid && tx_ready;
   // Two clocks after a rising SCLK edge the synchronised MISO reflects the
   // level present at that edge.
   assign sample     = (state == SHIFT) && spi_clk && (cnt == 8'd1);
   assign frame_done = (state == HOLD) && div_done;
   assign spi_mosi   = tx_sh[FRAME_BITS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= GAP;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      active_nx = 1'b0;
      case (state)
         IDLE:    if (accept) state_nx = SETUP;
         SETUP:   if (div_done) state_nx = SHIFT;
         SHIFT:   if (div_done && edge_cnt == EDGE_LAST) state_nx = HOLD;
         HOLD:    if (div_done) state_nx = GAP;
         GAP:     if (cnt == GAP_LAST) state_nx = IDLE;
         default: state_nx = GAP;
      endcase
      active_nx = (state_nx == SETUP) || (state_nx == SHIFT) || (state_nx == HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso_m <= 1'b0;
         miso_s <= 1'b0;
      end else begin
         miso_m <= spi_miso;
         miso_s <= miso_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         spi_clk  <= 1'b0;
         spi_cs   <= 1'b1;
         busy     <= 1'b0;
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         rx_id    <= '0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         spi_cs   <= ~active_nx;
         busy     <= active_nx;
         tx_ready <= (state_nx == IDLE);
         if ((state_nx != state) || (state == IDLE) || ((state == SHIFT) && div_done))
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;

         if (accept) begin
            tx_sh    <= {tx_id, tx_data};
            edge_cnt <= '0;
            spi_clk  <= 1'b0;
         end

         if (sample) rx_sh <= {rx_sh[FRAME_BITS-2:0], miso_s};

         if ((state == SHIFT) && div_done) begin
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_cnt + 1'b1;
            // The final falling edge leaves MOSI on the last bit.
            if (spi_clk && (edge_cnt != EDGE_LAST))
               tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
         end

         if (frame_done) begin
            rx_valid <= 1'b1;
            rx_id    <= rx_sh[FRAME_BITS-1:FRAME_BITS-4];
            rx_data  <= rx_sh[FRAME_BITS-5:0];
         end
      end
   end

`ifdef SPI_FRAME_EXPECT_EN
   logic                  exp_armed;
   logic [FRAME_BITS-1:0] exp_frame;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_armed <= 1'b0;
         exp_frame <= '0;
         exp_err   <= 1'b0;
         err_count <= '0;
      end else begin
         exp_err <= 1'b0;
         if (accept) begin
            exp_armed <= exp_valid;
            exp_frame <= {exp_id, exp_data};
         end else if (frame_done) begin
            exp_armed <= 1'b0;
            if (exp_armed && (rx_sh != exp_frame)) begin
               exp_err <= 1'b1;
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_frame_master: directed bench with a mode-0 slave model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_spi_frame_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [3:0]  tx_id = '0;
   logic [27:0] tx_data = '0;
   logic        rx_valid;
   logic [3:0]  rx_id;
   logic [27:0] rx_data;
   logic        busy, spi_clk, spi_mosi, spi_miso, spi_cs;
`ifdef SPI_FRAME_EXPECT_EN
   logic        exp_valid = 1'b0;
   logic [3:0]  exp_id = '0;
   logic [27:0] exp_data = '0;
   logic        exp_err;
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   spi_frame_master dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_id(tx_id), .tx_data(tx_data), .rx_valid(rx_valid), .rx_id(rx_id),
      .rx_data(rx_data), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs(spi_cs)
`ifdef SPI_FRAME_EXPECT_EN
      , .exp_valid(exp_valid), .exp_id(exp_id), .exp_data(exp_data),
      .exp_err(exp_err), .err_count(err_count)
`endif
   );

   // Mode-0 slave: reply MSB appears at CS fall, advances on each SCLK fall.
   logic [31:0] slave_reply = '0;
   logic [31:0] s_sh = '0;
   logic [31:0] s_rx = '0;
   logic        cs_hi = 1'b1;
   assign spi_miso = s_sh[31];

   always @(spi_cs or negedge spi_clk) begin
      if (spi_cs !== 1'b0) cs_hi = 1'b1;
      else if (cs_hi) begin
         cs_hi = 1'b0;
         s_sh  = slave_reply;
      end else s_sh = s_sh << 1;
   end

   int sclk_rises = 0;
   always @(posedge spi_clk) begin
      s_rx = {s_rx[30:0], spi_mosi};
      sclk_rises++;
   end

   int cs_falls = 0;
   always @(negedge spi_cs) cs_falls++;

   int cs_low = 0, rx_pulses = 0, hi_run = 0, last_gap = 0, ready_busy = 0;
   always @(posedge clk) begin
      if (spi_cs === 1'b0) begin
         cs_low++;
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
         if (tx_ready === 1'b1) ready_busy++;
      end else hi_run++;
      if (rx_valid === 1'b1) rx_pulses++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] id, input logic [27:0] d);
      int n;
      n = 0;
      @(negedge clk);
      tx_id    = id;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {31'd0, tx_ready}, 32'd1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   logic [3:0]  got_id;
   logic [27:0] got_data;
   logic        got_err;

   task automatic wait_rx();
      int n;
      n = 0;
      while (rx_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rx_seen", {31'd0, rx_valid}, 32'd1);
      got_id   = rx_id;
      got_data = rx_data;
      got_err  = 1'b0;
`ifdef SPI_FRAME_EXPECT_EN
      got_err  = exp_err;
`endif
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_low, t_rise, t_fall, t_rx, n;

      // Reset held, then released
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs",       {31'd0, spi_cs},   32'd1);
      check("rst_sclk",     {31'd0, spi_clk},  32'd0);
      check("rst_mosi",     {31'd0, spi_mosi}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_ready",    {31'd0, tx_ready}, 32'd0);
      check("rst_rx_data",  {4'd0, rx_data},   32'd0);
`ifdef SPI_FRAME_EXPECT_EN
      check("rst_err_count", {16'd0, err_count}, 32'd0);
`endif
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("ready_gap_early", {31'd0, tx_ready}, 32'd0);
      @(posedge clk);
      #1 check("ready_gap_done", {31'd0, tx_ready}, 32'd1);

      // Single frame: ID 14, payload 1, slave replies 0x0A000000
      slave_reply = 32'h0A00_0000;
      t_low = cs_low; t_rise = sclk_rises; t_rx = rx_pulses;
      send(4'd14, 28'h000_0001);
      wait_rx();
      check("f1_rx_id",    {28'd0, got_id},   32'd0);
      check("f1_rx_data",  {4'd0, got_data},  32'h0A00_0000);
      check("f1_mosi",     s_rx,              32'hE000_0001);
      check("f1_cs_low",   cs_low - t_low,    32'd264);
      check("f1_sclk",     sclk_rises - t_rise, 32'd32);
      repeat (10) @(negedge clk);
      check("f1_rx_pulse", rx_pulses - t_rx,  32'd1);
      check("f1_rx_held",  {4'd0, rx_data},   32'h0A00_0000);

      // Back-to-back frames, replies 1 then 0
      slave_reply = 32'h0000_0001;
      send(4'd0, 28'd0);
      wait_rx();
      check("b2b_1_data", {4'd0, got_data}, 32'd1);
      slave_reply = 32'h0000_0000;
      send(4'd0, 28'd0);
      wait_rx();
      check("b2b_2_data", {4'd0, got_data}, 32'd0);
      check("b2b_2_id",   {28'd0, got_id},  32'd0);
      check("b2b_gap_min", {31'd0, (last_gap >= 4)}, 32'd1);

      // tx_valid pulsed mid-frame is ignored
      slave_reply = 32'h0FFF_FFFF;
      t_fall = cs_falls; t_rx = rx_pulses;
      send(4'd3, 28'h123_4567);
      repeat (40) @(negedge clk);
      tx_id = 4'd9; tx_valid = 1'b1;
      check("mid_ready", {31'd0, tx_ready}, 32'd0);
      check("mid_busy",  {31'd0, busy},     32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_rx();
      check("mid_rx_data", {4'd0, got_data}, 32'h0FFF_FFFF);
      check("mid_mosi",    s_rx,             32'h3123_4567);
      repeat (20) @(negedge clk);
      check("mid_one_frame", cs_falls - t_fall,  32'd1);
      check("mid_one_rx",    rx_pulses - t_rx,   32'd1);
      check("mid_ready_busy", ready_busy,        32'd0);

      // Reset during bit 10
      slave_reply = 32'hFFFF_FFFF;
      t_rise = sclk_rises; t_rx = rx_pulses;
      send(4'd7, 28'h0FF_00FF);
      n = 0;
      while ((sclk_rises - t_rise) < 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst10_reached", sclk_rises - t_rise, 32'd10);
      #1 rst = 1'b1;
      #1;
      check("rst10_cs",   {31'd0, spi_cs},  32'd1);
      check("rst10_sclk", {31'd0, spi_clk}, 32'd0);
      check("rst10_busy", {31'd0, busy},    32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      check("rst10_no_rx",   rx_pulses - t_rx, 32'd0);
      check("rst10_rx_data", {4'd0, rx_data},  32'd0);
      slave_reply = 32'h1234_5678;
      send(4'd5, 28'h0AB_CDEF);
      wait_rx();
      check("post_rst_id",   {28'd0, got_id},  32'd1);
      check("post_rst_data", {4'd0, got_data}, 32'h0234_5678);
      check("post_rst_mosi", s_rx,             32'h50AB_CDEF);

`ifdef SPI_FRAME_EXPECT_EN
      // Armed expectation mismatching, then matching
      exp_valid = 1'b1; exp_id = 4'd0; exp_data = 28'hA00_0000;
      slave_reply = 32'h0A00_0001;
      send(4'd1, 28'd0);
      exp_valid = 1'b0;
      wait_rx();
      check("exp_err_pulse", {31'd0, got_err},   32'd1);
      check("exp_count_1",   {16'd0, err_count}, 32'd1);
      exp_valid = 1'b1;
      slave_reply = 32'h0A00_0000;
      send(4'd1, 28'd0);
      exp_valid = 1'b0;
      wait_rx();
      check("exp_match_err", {31'd0, got_err},   32'd0);
      check("exp_count_kept", {16'd0, err_count}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
